// File: rtl/rename_record_queue_mw.sv
// Multi-lane rename record queue: ENQ_W-wide enqueue, DEQ_W-wide show-ahead dequeue,
// one tail checkpoint for squash, plus flush. Define RRQ_ERR_CHECK_EN to add the err_sticky port.
module rename_record_queue_mw #(
    parameter int DATA_WIDTH  = 8,
    parameter int TABLE_DEPTH = 16,
    parameter int ENQ_W       = 2,
    parameter int DEQ_W       = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ENQ_W-1:0]                  enq_valid,
    input  logic [ENQ_W*DATA_WIDTH-1:0]       enq_data,
    output logic                              enq_ready,
    output logic [DEQ_W-1:0]                  deq_valid,
    output logic [DEQ_W*DATA_WIDTH-1:0]       deq_data,
    input  logic [$clog2(DEQ_W+1)-1:0]        deq_pop,
    input  logic                              ckpt_save,
    input  logic                              ckpt_restore,
    input  logic                              flush,
    output logic [$clog2(TABLE_DEPTH+1)-1:0]  count,
    output logic                              table_full,
    output logic                              table_empty
`ifdef RRQ_ERR_CHECK_EN
    ,
    output logic                              err_sticky
`endif
);

    localparam int IW = $clog2(TABLE_DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(TABLE_DEPTH + 1);
    localparam int EW = $clog2(ENQ_W + 1);

    // Length of the run of ones starting at lane 0; lanes past the first zero are dropped.
    function automatic logic [EW-1:0] lead_ones(input logic [ENQ_W-1:0] v);
        logic [EW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < ENQ_W; i++) begin
            if (run && v[i]) begin
                n = n + EW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // True when the mask is a clean thermometer code from lane 0.
    function automatic logic is_thermo(input logic [ENQ_W-1:0] v, input logic [EW-1:0] n);
        logic [ENQ_W-1:0] m;
        for (int i = 0; i < ENQ_W; i++) begin
            m[i] = (EW'(i) < n);
        end
        return (m == v);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [TABLE_DEPTH];
    logic [PW-1:0]         head_r, tail_r, ckpt_r;
    logic                  ckpt_valid_r;
    logic [CW-1:0]         count_r;
    logic                  full_r, empty_r, ready_r;
    logic [DEQ_W-1:0]      deq_valid_r;
    logic                  err_r;

    logic [EW-1:0]         n_enq_s;
    logic [CW-1:0]         pop_ext_s, n_pop_s;
    logic [PW-1:0]         new_head_s, ckpt_dist_s;
    logic                  restore_s, enq_fire_s;
    logic [PW-1:0]         head_next_s, tail_next_s, ckpt_next_s;
    logic                  ckpt_valid_next_s;
    logic [CW-1:0]         count_next_s;
    logic [DEQ_W-1:0]      deq_valid_next_s;
    logic                  err_next_s;
    logic [PW-1:0]         wr_ptr_s [ENQ_W];
    logic [PW-1:0]         rd_ptr_s [DEQ_W];

    // Per-cycle decode of enqueue width, clamped pop and restore qualification.
    always_comb begin
        n_enq_s     = lead_ones(enq_valid);
        pop_ext_s   = CW'(deq_pop);
        if (pop_ext_s > count_r) begin
            n_pop_s = count_r;
        end else begin
            n_pop_s = pop_ext_s;
        end
        new_head_s  = head_r + PW'(n_pop_s);
        ckpt_dist_s = ckpt_r - new_head_s;
        restore_s   = ckpt_restore && ckpt_valid_r;
        enq_fire_s  = ready_r && (n_enq_s != '0) && !restore_s && !flush && !reset;
    end

    // Next pointer/checkpoint state; flush outranks restore, restore outranks enqueue/save.
    always_comb begin
        head_next_s       = head_r;
        tail_next_s       = tail_r;
        ckpt_next_s       = ckpt_r;
        ckpt_valid_next_s = ckpt_valid_r;
        if (flush) begin
            head_next_s       = '0;
            tail_next_s       = '0;
            ckpt_valid_next_s = 1'b0;
        end else begin
            head_next_s = new_head_s;
            if (restore_s) begin
                // A checkpoint already overtaken by retirement collapses to an empty queue.
                if (ckpt_dist_s <= PW'(TABLE_DEPTH)) begin
                    tail_next_s = ckpt_r;
                end else begin
                    tail_next_s = new_head_s;
                end
                ckpt_valid_next_s = 1'b0;
            end else begin
                if (enq_fire_s) begin
                    tail_next_s = tail_r + PW'(n_enq_s);
                end else begin
                    tail_next_s = tail_r;
                end
                if (ckpt_save) begin
                    ckpt_next_s       = tail_r;
                    ckpt_valid_next_s = 1'b1;
                end else begin
                    ckpt_next_s       = ckpt_r;
                    ckpt_valid_next_s = ckpt_valid_r;
                end
            end
        end
        count_next_s = CW'(tail_next_s - head_next_s);
        for (int i = 0; i < DEQ_W; i++) begin
            deq_valid_next_s[i] = (count_next_s > CW'(i));
        end
    end

    // Sticky protocol-violation detector.
    always_comb begin
        err_next_s = err_r;
        if (((enq_valid != '0) && !ready_r) || !is_thermo(enq_valid, n_enq_s) ||
            (pop_ext_s > count_r) || (ckpt_restore && !ckpt_valid_r)) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_r;
        end
    end

    // Pointer, checkpoint and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= '0;
            tail_r       <= '0;
            ckpt_r       <= '0;
            ckpt_valid_r <= 1'b0;
            count_r      <= '0;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            ready_r      <= 1'b1;
            deq_valid_r  <= '0;
            err_r        <= 1'b0;
        end else begin
            head_r       <= head_next_s;
            tail_r       <= tail_next_s;
            ckpt_r       <= ckpt_next_s;
            ckpt_valid_r <= ckpt_valid_next_s;
            count_r      <= count_next_s;
            full_r       <= (count_next_s == CW'(TABLE_DEPTH));
            empty_r      <= (count_next_s == '0);
            ready_r      <= (count_next_s <= CW'(TABLE_DEPTH - ENQ_W));
            deq_valid_r  <= deq_valid_next_s;
            err_r        <= err_next_s;
        end
    end

    // Lane read/write pointers; lanes wrap from DEPTH-1 to 0 through the index bits.
    always_comb begin
        for (int i = 0; i < ENQ_W; i++) begin
            wr_ptr_s[i] = tail_r + PW'(i);
        end
        for (int i = 0; i < DEQ_W; i++) begin
            rd_ptr_s[i] = head_r + PW'(i);
            deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr_s[i][IW-1:0]];
        end
    end

    // Record storage; only lanes within the accepted run are written.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (EW'(i) < n_enq_s) begin
                    mem_r[wr_ptr_s[i][IW-1:0]] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign enq_ready   = ready_r;
    assign deq_valid   = deq_valid_r;
    assign count       = count_r;
    assign table_full  = full_r;
    assign table_empty = empty_r;
`ifdef RRQ_ERR_CHECK_EN
    assign err_sticky  = err_r;
`endif

endmodule

// File: tb/tb_rename_record_queue_mw.sv
// Self-checking bench for rename_record_queue_mw: directed table, corner sequences,
// and randomized traffic against a pointer-arithmetic reference model.
module tb_rename_record_queue_mw;

    logic        clk;
    logic        reset;
    logic [1:0]  enq_valid;
    logic [15:0] enq_data;
    logic        enq_ready;
    logic [1:0]  deq_valid;
    logic [15:0] deq_data;
    logic [1:0]  deq_pop;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic        flush;
    logic [4:0]  count;
    logic        table_full;
    logic        table_empty;
`ifdef RRQ_ERR_CHECK_EN
    logic        err_sticky;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state: absolute pointers modulo 32, physical memory image
    int       mh, mt, mc;
    bit       mcv, merr;
    bit [7:0] mmem   [16];
    bit       mknown [16];

    rename_record_queue_mw #(
        .DATA_WIDTH(8), .TABLE_DEPTH(16), .ENQ_W(2), .DEQ_W(2)
    ) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_data(deq_data), .deq_pop(deq_pop),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .flush(flush),
        .count(count), .table_full(table_full), .table_empty(table_empty)
`ifdef RRQ_ERR_CHECK_EN
        , .err_sticky(err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_in(input logic [1:0] ev, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [1:0] pop, input logic sv, input logic rs, input logic fl);
        enq_valid    = ev;
        enq_data     = {d1, d0};
        deq_pop      = pop;
        ckpt_save    = sv;
        ckpt_restore = rs;
        flush        = fl;
    endtask

    task automatic model_step();
        int cnt, npop, nh, nenq, old_t;
        bit ready;
        cnt   = (mt - mh) & 31;
        ready = (16 - cnt) >= 2;
        nenq  = enq_valid[0] ? (enq_valid[1] ? 2 : 1) : 0;
        if (reset) begin
            merr = 1'b0;
        end else if (((enq_valid != 2'b00) && !ready) || (enq_valid == 2'b10) ||
                     (int'(deq_pop) > cnt) || (ckpt_restore && !mcv)) begin
            merr = 1'b1;
        end
        if (reset) begin
            mh = 0; mt = 0; mc = 0; mcv = 1'b0;
        end else if (flush) begin
            mh = 0; mt = 0; mcv = 1'b0;
        end else begin
            npop = (int'(deq_pop) > cnt) ? cnt : int'(deq_pop);
            nh   = (mh + npop) & 31;
            if (ckpt_restore && mcv) begin
                mt  = (((mc - nh) & 31) <= 16) ? mc : nh;
                mcv = 1'b0;
            end else begin
                old_t = mt;
                if (ready) begin
                    for (int i = 0; i < nenq; i++) begin
                        mmem[(mt + i) % 16]   = enq_data[i*8 +: 8];
                        mknown[(mt + i) % 16] = 1'b1;
                    end
                    mt = (mt + nenq) & 31;
                end
                if (ckpt_save) begin
                    mc  = old_t;
                    mcv = 1'b1;
                end
            end
            mh = nh;
        end
    endtask

    task automatic model_check();
        int cnt;
        cnt = (mt - mh) & 31;
        chk("count", 32'(count), 32'(cnt));
        chk("table_full", 32'(table_full), 32'(cnt == 16));
        chk("table_empty", 32'(table_empty), 32'(cnt == 0));
        chk("enq_ready", 32'(enq_ready), 32'(cnt <= 14));
        chk("deq_valid", 32'(deq_valid), 32'({cnt > 1, cnt > 0}));
        for (int i = 0; i < 2; i++) begin
            if (cnt > i && mknown[(mh + i) % 16]) begin
                chk($sformatf("deq_data lane%0d", i), 32'(deq_data[i*8 +: 8]),
                    32'(mmem[(mh + i) % 16]));
            end
        end
`ifdef RRQ_ERR_CHECK_EN
        chk("err_sticky", 32'(err_sticky), 32'(merr));
`endif
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0] ev;
        logic [7:0] d0, d1;
        logic [1:0] pop;
        logic       sv, rs, fl;
        logic [4:0] exp_count;
        logic [1:0] exp_dv;
        logic [7:0] exp_l0, exp_l1;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{2'b11, 8'h11, 8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 5'd2, 2'b11, 8'h11, 8'h22};
        tbl[1] = '{2'b11, 8'h33, 8'h44, 2'd0, 1'b1, 1'b0, 1'b0, 5'd4, 2'b11, 8'h11, 8'h22};
        tbl[2] = '{2'b11, 8'h55, 8'h66, 2'd0, 1'b0, 1'b1, 1'b0, 5'd2, 2'b11, 8'h11, 8'h22};
        tbl[3] = '{2'b01, 8'h77, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 5'd3, 2'b11, 8'h11, 8'h22};
        tbl[4] = '{2'b00, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, 5'd1, 2'b01, 8'h77, 8'h00};
        tbl[5] = '{2'b10, 8'h88, 8'h99, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 8'h00, 8'h00};
        tbl[6] = '{2'b11, 8'hAA, 8'hBB, 2'd1, 1'b0, 1'b0, 1'b0, 5'd2, 2'b11, 8'hAA, 8'hBB};
        tbl[7] = '{2'b11, 8'hCC, 8'hDD, 2'd2, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 8'h00, 8'h00};
        tbl[8] = '{2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 8'h00, 8'h00};
        tbl[9] = '{2'b11, 8'hCC, 8'hDD, 2'd2, 1'b0, 1'b0, 1'b0, 5'd2, 2'b11, 8'hCC, 8'hDD};

        mh = 0; mt = 0; mc = 0; mcv = 1'b0; merr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mknown[i] = 1'b0;
            mmem[i]   = 8'h00;
        end
        reset = 1'b1;
        set_in(2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(table_empty), 32'd1);
        chk("reset full", 32'(table_full), 32'd0);
        chk("reset ready", 32'(enq_ready), 32'd1);
        chk("reset deq_valid", 32'(deq_valid), 32'd0);
`ifdef RRQ_ERR_CHECK_EN
        chk("reset err_sticky", 32'(err_sticky), 32'd0);
`endif

        // directed table: basic enqueue, checkpoint squash, partial lanes, flush
        for (int v = 0; v < 10; v++) begin
            set_in(tbl[v].ev, tbl[v].d0, tbl[v].d1, tbl[v].pop, tbl[v].sv, tbl[v].rs, tbl[v].fl);
            tick();
            chk($sformatf("tbl%0d count", v), 32'(count), 32'(tbl[v].exp_count));
            chk($sformatf("tbl%0d deq_valid", v), 32'(deq_valid), 32'(tbl[v].exp_dv));
            if (tbl[v].exp_dv[0]) chk($sformatf("tbl%0d lane0", v), 32'(deq_data[7:0]), 32'(tbl[v].exp_l0));
            if (tbl[v].exp_dv[1]) chk($sformatf("tbl%0d lane1", v), 32'(deq_data[15:8]), 32'(tbl[v].exp_l1));
        end

        // fill to full, overflow drop, then wrap the head to index 14
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(2'b11, 8'(2 * i), 8'(2 * i + 1), 2'd0, 1'b0, 1'b0, 1'b0);
            tick();
            if (i == 6) begin
                chk("fill7 count", 32'(count), 32'd14);
                chk("fill7 ready", 32'(enq_ready), 32'd1);
            end
            if (i >= 7) begin
                chk("full count", 32'(count), 32'd16);
                chk("full flag", 32'(table_full), 32'd1);
                chk("full ready", 32'(enq_ready), 32'd0);
                chk("full lane0", 32'(deq_data[7:0]), 32'h00);
            end
        end
        for (int i = 0; i < 7; i++) begin
            set_in(2'b00, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("head14 count", 32'(count), 32'd2);
        chk("head14 lane0", 32'(deq_data[7:0]), 32'd14);
        chk("head14 lane1", 32'(deq_data[15:8]), 32'd15);
        set_in(2'b11, 8'h33, 8'h44, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wrap count", 32'(count), 32'd2);
        chk("wrap lane0", 32'(deq_data[7:0]), 32'h33);
        chk("wrap lane1", 32'(deq_data[15:8]), 32'h44);

        // restore to a checkpoint already retired past -> empty
        do_reset();
        set_in(2'b11, 8'hA1, 8'hB2, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        set_in(2'b11, 8'hC3, 8'hD4, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        set_in(2'b00, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0); tick();
        set_in(2'b00, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0); tick();
        set_in(2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); tick();
        chk("stale restore count", 32'(count), 32'd0);
        chk("stale restore empty", 32'(table_empty), 32'd1);

        // flush with enqueue and pop at count 5, then restore is a no-op
        do_reset();
        set_in(2'b11, 8'h01, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        set_in(2'b11, 8'h03, 8'h04, 2'd0, 1'b1, 1'b0, 1'b0); tick();
        set_in(2'b01, 8'h05, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        chk("pre-flush count", 32'(count), 32'd5);
        set_in(2'b11, 8'hEE, 8'hFF, 2'd2, 1'b0, 1'b0, 1'b1); tick();
        chk("flush count", 32'(count), 32'd0);
        chk("flush empty", 32'(table_empty), 32'd1);
        set_in(2'b00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); tick();
        chk("noop restore count", 32'(count), 32'd0);
`ifdef RRQ_ERR_CHECK_EN
        chk("err after bad restore", 32'(err_sticky), 32'd1);
        do_reset();
        chk("err cleared", 32'(err_sticky), 32'd0);
        set_in(2'b00, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0); tick();
        chk("err after over-pop", 32'(err_sticky), 32'd1);
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 255) == 0);
            set_in(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   2'($urandom_range(0, 4) > 2 ? $urandom_range(1, 2) : 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 59) == 0));
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
